velocity_to_rpm: RTL and testbench



---
 rtl/drag_pkg.sv | 37 +++
 rtl/serial_divider.sv | 58 +++++
 rtl/velocity_to_rpm.sv | 84 ++++++++
 tb/tb_velocity_to_rpm.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/drag_pkg.sv
// rtl/drag_pkg.sv - shared drivetrain constants for the rpm/speed conversion paths
package drag_pkg;

    localparam int VEL_SHIFT = 13;
    localparam int VEL_W     = 18;
    localparam int RPM_W     = 14;
    localparam int DIV_W     = 5;

    localparam logic [DIV_W-1:0] GEAR_RATIO_1 = 5'd9;
    localparam logic [DIV_W-1:0] GEAR_RATIO_2 = 5'd13;
    localparam logic [DIV_W-1:0] GEAR_RATIO_3 = 5'd18;
    localparam logic [DIV_W-1:0] GEAR_RATIO_4 = 5'd25;

    localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
    localparam logic [1:0] ST_DIVIDE_ENC = 2'd1;
    localparam logic [1:0] ST_CLAMP_ENC  = 2'd2;
    localparam logic [1:0] ST_DONE_ENC   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE_ENC,
        S_DIVIDE = ST_DIVIDE_ENC,
        S_CLAMP  = ST_CLAMP_ENC,
        S_DONE   = ST_DONE_ENC
    } v2r_state_t;

    function automatic logic [DIV_W-1:0] gear_ratio(input logic [1:0] gear);
        logic [DIV_W-1:0] r;
        case (gear)
            2'd0:    r = GEAR_RATIO_1;
            2'd1:    r = GEAR_RATIO_2;
            2'd2:    r = GEAR_RATIO_3;
            default: r = GEAR_RATIO_4;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/serial_divider.sv
// rtl/serial_divider.sv - unsigned restoring divider, one quotient bit per cycle, MSB first
// done is high during the final iteration cycle; quotient is final from the next cycle on.
module serial_divider
    import drag_pkg::*;
(
    input  logic             clk100Hz,
    input  logic             rst,
    input  logic             start,
    input  logic [VEL_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic             done,
    output logic [VEL_W-1:0] quotient
);

    localparam logic [4:0] LAST_ITER = 5'(VEL_W - 1);

    logic [VEL_W-1:0] dividend_q;
    logic [DIV_W-1:0] divisor_q;
    logic [DIV_W-1:0] rem_q;
    logic [4:0]       count_q;
    logic             running_q;

    logic [DIV_W:0]   shifted;
    logic [DIV_W:0]   diff;
    logic             fits;

    // rem < divisor <= 31, so the shifted partial remainder always fits in DIV_W+1 bits
    assign shifted = {rem_q, dividend_q[VEL_W-1]};
    assign diff    = shifted - {1'b0, divisor_q};
    assign fits    = shifted >= {1'b0, divisor_q};
    assign done    = running_q && (count_q == 5'd0);

    always_ff @(posedge clk100Hz) begin
        if (rst) begin
            dividend_q <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            quotient   <= '0;
            count_q    <= '0;
            running_q  <= 1'b0;
        end else if (start) begin
            dividend_q <= dividend;
            divisor_q  <= divisor;
            rem_q      <= '0;
            quotient   <= '0;
            count_q    <= LAST_ITER;
            running_q  <= 1'b1;
        end else if (running_q) begin
            rem_q      <= fits ? diff[DIV_W-1:0] : shifted[DIV_W-1:0];
            quotient   <= {quotient[VEL_W-2:0], fits};
            dividend_q <= {dividend_q[VEL_W-2:0], 1'b0};
            count_q    <= count_q - 5'd1;
            if (count_q == 5'd0)
                running_q <= 1'b0;
        end
    end

endmodule

// File: rtl/velocity_to_rpm.sv
// rtl/velocity_to_rpm.sv - recomputes engine rpm from vehicle speed on a gear change
module velocity_to_rpm
    import drag_pkg::*;
#(
    parameter int unsigned RPM_MAX  = 9000,
    parameter int unsigned RPM_IDLE = 1000
) (
    input  logic             clk100Hz,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       d_position,
    input  logic [1:0]       gear,
    input  logic             reset_status,
    output logic             busy,
    output logic             done,
    output logic [RPM_W-1:0] rpm
);

    localparam logic [VEL_W-1:0] Q_MAX  = VEL_W'(RPM_MAX);
    localparam logic [VEL_W-1:0] Q_IDLE = VEL_W'(RPM_IDLE);

    v2r_state_t       state;
    logic             div_start;
    logic             div_done;
    logic [VEL_W-1:0] quotient;
    logic [VEL_W-1:0] dividend;
    logic [RPM_W-1:0] clamped;

    assign dividend  = {d_position, {VEL_SHIFT{1'b0}}};
    assign div_start = (state == S_IDLE) && start && !reset_status;

    serial_divider u_div (
        .clk100Hz (clk100Hz),
        .rst      (rst),
        .start    (div_start),
        .dividend (dividend),
        .divisor  (gear_ratio(gear)),
        .done     (div_done),
        .quotient (quotient)
    );

    // Full-width compare first: gear 0 quotients exceed the 14-bit rpm range
    always_comb begin
        clamped = quotient[RPM_W-1:0];
        if (quotient > Q_MAX)
            clamped = RPM_W'(RPM_MAX);
        else if (quotient < Q_IDLE)
            clamped = RPM_W'(RPM_IDLE);
    end

    always_ff @(posedge clk100Hz) begin
        if (rst || reset_status) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            rpm   <= RPM_W'(RPM_IDLE);
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= S_DIVIDE;
                        busy  <= 1'b1;
                    end
                end
                S_DIVIDE: begin
                    if (div_done)
                        state <= S_CLAMP;
                end
                S_CLAMP: begin
                    state <= S_DONE;
                    rpm   <= clamped;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_velocity_to_rpm.sv
// tb/tb_velocity_to_rpm.sv - randomized self-checking bench for velocity_to_rpm
module tb_velocity_to_rpm;

    logic        clk100Hz = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  d_position;
    logic [1:0]  gear;
    logic        reset_status;
    logic        busy;
    logic        done;
    logic [13:0] rpm;

    int errors = 0;
    int checks = 0;

    always #5 clk100Hz = ~clk100Hz;

    velocity_to_rpm dut (
        .clk100Hz     (clk100Hz),
        .rst          (rst),
        .start        (start),
        .d_position   (d_position),
        .gear         (gear),
        .reset_status (reset_status),
        .busy         (busy),
        .done         (done),
        .rpm          (rpm)
    );

    function automatic int model_rpm(input int d, input int g);
        int ratios[4];
        int q;
        ratios = '{9, 13, 18, 25};
        q = (d * 8192) / ratios[g];
        if (q > 9000) return 9000;
        if (q < 1000) return 1000;
        return q;
    endfunction

    task automatic tick();
        @(posedge clk100Hz);
        #1;
    endtask

    // Pulses start, then observes the 21 cycles after the accepting edge N.
    // inject_at >= 0 pulses a second start (d=31, gear 0) sampled at edge N+inject_at.
    task automatic run_one(input int d, input int g, input int inject_at, input string name);
        int busy_cnt;
        int done_cnt;
        int done_at;
        int got;
        int exp_rpm;
        exp_rpm = model_rpm(d, g);
        busy_cnt = 0;
        done_cnt = 0;
        done_at = -1;
        got = -1;
        start = 1'b1;
        d_position = 5'(d);
        gear = 2'(g);
        tick();
        start = 1'b0;
        d_position = 5'($urandom);
        gear = 2'($urandom);
        for (int k = 0; k <= 20; k++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = k;
                    got = int'(rpm);
                end
            end
            if (inject_at >= 0 && k == inject_at - 1) begin
                start = 1'b1;
                d_position = 5'd31;
                gear = 2'd0;
            end else begin
                start = 1'b0;
            end
            if (k < 20) tick();
        end
        checks++;
        if (got !== exp_rpm) begin
            errors++;
            $display("FAIL %s rpm: got %0d expected %0d", name, got, exp_rpm);
        end
        checks++;
        if (done_at !== 19 || done_cnt !== 1) begin
            errors++;
            $display("FAIL %s done_timing: at %0d count %0d expected at 19 count 1", name, done_at, done_cnt);
        end
        checks++;
        if (busy_cnt !== 19) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d expected 19", name, busy_cnt);
        end
        checks++;
        if (int'(rpm) !== exp_rpm || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s hold: rpm %0d busy %0b expected rpm %0d busy 0", name, rpm, busy, exp_rpm);
        end
    endtask

    task automatic expect_idle_abort(input string name);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || rpm !== 14'd1000) begin
            errors++;
            $display("FAIL %s: busy %0b done %0b rpm %0d expected 0 0 1000", name, busy, done, rpm);
        end
    endtask

    task automatic expect_no_done(input int cycles, input string name);
        int seen;
        seen = 0;
        for (int k = 0; k < cycles; k++) begin
            if (done || busy) seen++;
            tick();
        end
        checks++;
        if (seen !== 0 || rpm !== 14'd1000) begin
            errors++;
            $display("FAIL %s: active cycles %0d rpm %0d expected 0 and 1000", name, seen, rpm);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        reset_status = 1'b0;
        d_position = '0;
        gear = '0;
        tick();
        tick();
        rst = 1'b0;
        expect_idle_abort("reset_state");
        tick();
    endtask

    task automatic test_directed();
        run_one(10, 1, -1, "d10_g1");
        run_one(20, 3, -1, "d20_g3_trunc");
        run_one(31, 0, -1, "d31_g0_upper");
        run_one(0, 2, -1, "d0_lower");
    endtask

    task automatic test_abort();
        run_one(10, 1, -1, "pre_abort");
        start = 1'b1;
        d_position = 5'd10;
        gear = 2'd1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        reset_status = 1'b1;
        tick();
        reset_status = 1'b0;
        expect_idle_abort("abort_state");
        expect_no_done(25, "abort_no_done");
        run_one(10, 1, -1, "after_abort");
    endtask

    task automatic test_rst_mid();
        start = 1'b1;
        d_position = 5'd20;
        gear = 2'd3;
        tick();
        start = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_idle_abort("rst_mid_state");
        expect_no_done(25, "rst_mid_no_done");
        run_one(20, 3, -1, "after_rst");
    endtask

    task automatic test_ignored_start();
        run_one(10, 1, 5, "ignored_start");
    endtask

    task automatic test_start_with_abort();
        run_one(20, 3, -1, "pre_collision");
        start = 1'b1;
        reset_status = 1'b1;
        d_position = 5'd31;
        gear = 2'd0;
        tick();
        start = 1'b0;
        reset_status = 1'b0;
        expect_idle_abort("collision_state");
        expect_no_done(25, "collision_no_done");
    endtask

    task automatic test_back_to_back_random();
        for (int i = 0; i < 20; i++) begin
            run_one(int'($urandom_range(0, 31)), int'($urandom_range(0, 3)), -1, $sformatf("rand%0d", i));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_abort();
        test_rst_mid();
        test_ignored_start();
        test_start_with_abort();
        test_back_to_back_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
